// File: rtl/axis_rr_arbiter.sv
// N-to-1 AXI-Stream packet arbiter: round-robin grant per packet, lock held until TLAST.
// Optional macro AXIS_ARB_TID_TAG_EN stamps grant_idx into the low bits of m_tid.
module axis_rr_arbiter #(
  parameter int NUM_SRC     = 4,
  parameter int TDATA_WIDTH = 8,
  parameter int TDEST_WIDTH = 8,
  parameter int TUSER_WIDTH = 1,
  parameter int TID_WIDTH   = 8,
  localparam int KW = TDATA_WIDTH / 8,
  localparam int IW = $clog2(NUM_SRC)
) (
  input  logic                             ACLK,
  input  logic                             ARESETn,
  input  logic [NUM_SRC-1:0]               s_tvalid,
  output logic [NUM_SRC-1:0]               s_tready,
  input  logic [NUM_SRC*TDATA_WIDTH-1:0]   s_tdata,
  input  logic [NUM_SRC*KW-1:0]            s_tkeep,
  input  logic [NUM_SRC*KW-1:0]            s_tstrb,
  input  logic [NUM_SRC-1:0]               s_tlast,
  input  logic [NUM_SRC*TID_WIDTH-1:0]     s_tid,
  input  logic [NUM_SRC*TDEST_WIDTH-1:0]   s_tdest,
  input  logic [NUM_SRC*TUSER_WIDTH-1:0]   s_tuser,
  output logic                             m_tvalid,
  input  logic                             m_tready,
  output logic [TDATA_WIDTH-1:0]           m_tdata,
  output logic [KW-1:0]                    m_tkeep,
  output logic [KW-1:0]                    m_tstrb,
  output logic                             m_tlast,
  output logic [TID_WIDTH-1:0]             m_tid,
  output logic [TDEST_WIDTH-1:0]           m_tdest,
  output logic [TUSER_WIDTH-1:0]           m_tuser,
  output logic                             grant_valid,
  output logic [IW-1:0]                    grant_idx
);

  typedef enum logic {ST_IDLE, ST_LOCK} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] pick;
  logic          any_req;

  logic [TDATA_WIDTH-1:0] data_a [NUM_SRC];
  logic [KW-1:0]          keep_a [NUM_SRC];
  logic [KW-1:0]          strb_a [NUM_SRC];
  logic [TID_WIDTH-1:0]   id_a   [NUM_SRC];
  logic [TDEST_WIDTH-1:0] dest_a [NUM_SRC];
  logic [TUSER_WIDTH-1:0] user_a [NUM_SRC];

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
    assign data_a[g] = s_tdata[g*TDATA_WIDTH +: TDATA_WIDTH];
    assign keep_a[g] = s_tkeep[g*KW +: KW];
    assign strb_a[g] = s_tstrb[g*KW +: KW];
    assign id_a[g]   = s_tid[g*TID_WIDTH +: TID_WIDTH];
    assign dest_a[g] = s_tdest[g*TDEST_WIDTH +: TDEST_WIDTH];
    assign user_a[g] = s_tuser[g*TUSER_WIDTH +: TUSER_WIDTH];
  end

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
    return IW'((int'(base) + off) % NUM_SRC);
  endfunction

  // Search starts just after the previous winner, so the last grantee ranks lowest.
  always_comb begin
    pick    = last_q;
    any_req = 1'b0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      if (!any_req && s_tvalid[wrap_add(last_q, i)]) begin
        any_req = 1'b1;
        pick    = wrap_add(last_q, i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_LOCK;
          grant_d = pick;
        end
      end
      ST_LOCK: begin
        if (m_tvalid && m_tready && m_tlast) begin
          state_d = ST_IDLE;
          last_d  = grant_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s_tready = '0;
    m_tvalid = 1'b0;
    m_tdata  = '0;
    m_tkeep  = '0;
    m_tstrb  = '0;
    m_tlast  = 1'b0;
    m_tid    = '0;
    m_tdest  = '0;
    m_tuser  = '0;
    if (state_q == ST_LOCK) begin
      m_tvalid          = s_tvalid[grant_q];
      s_tready[grant_q] = m_tready;
      m_tdata           = data_a[grant_q];
      m_tkeep           = keep_a[grant_q];
      m_tstrb           = strb_a[grant_q];
      m_tlast           = s_tlast[grant_q];
      m_tid             = id_a[grant_q];
      m_tdest           = dest_a[grant_q];
      m_tuser           = user_a[grant_q];
`ifdef AXIS_ARB_TID_TAG_EN
      m_tid[IW-1:0]     = grant_q;
`endif
    end
  end

  // last_q resets to the top index so source 0 wins the first arbitration.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= IW'(NUM_SRC - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  assign grant_valid = (state_q == ST_LOCK);
  assign grant_idx   = grant_q;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Bench for axis_rr_arbiter: directed scenarios plus a randomized run, each cycle
// compared against a packet-level reference model of the arbitration rules.
module tb_axis_rr_arbiter;
  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int KW  = 1;
  localparam int TW  = 8;
  localparam int DEW = 8;
  localparam int UW  = 1;
  localparam int IW  = 2;

`ifdef AXIS_ARB_TID_TAG_EN
  localparam logic [7:0] EXP_TID = 8'hF3;
`else
  localparam logic [7:0] EXP_TID = 8'hF0;
`endif

  logic              ACLK = 1'b0;
  logic              ARESETn = 1'b0;
  logic [N-1:0]      s_tvalid, s_tready, s_tlast;
  logic [N*DW-1:0]   s_tdata;
  logic [N*KW-1:0]   s_tkeep, s_tstrb;
  logic [N*TW-1:0]   s_tid;
  logic [N*DEW-1:0]  s_tdest;
  logic [N*UW-1:0]   s_tuser;
  logic              m_tvalid, m_tready, m_tlast;
  logic [DW-1:0]     m_tdata;
  logic [KW-1:0]     m_tkeep, m_tstrb;
  logic [TW-1:0]     m_tid;
  logic [DEW-1:0]    m_tdest;
  logic [UW-1:0]     m_tuser;
  logic              grant_valid;
  logic [IW-1:0]     grant_idx;

  always #5 ACLK = ~ACLK;

  axis_rr_arbiter #(
    .NUM_SRC(N), .TDATA_WIDTH(DW), .TDEST_WIDTH(DEW), .TUSER_WIDTH(UW), .TID_WIDTH(TW)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
    .s_tstrb(s_tstrb), .s_tlast(s_tlast), .s_tid(s_tid), .s_tdest(s_tdest), .s_tuser(s_tuser),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
    .m_tstrb(m_tstrb), .m_tlast(m_tlast), .m_tid(m_tid), .m_tdest(m_tdest), .m_tuser(m_tuser),
    .grant_valid(grant_valid), .grant_idx(grant_idx)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       keep;
    logic       strb;
    logic       last;
    logic [7:0] tid;
    logic [7:0] dest;
    logic       user;
  } beat_t;

  beat_t srcq [N][$];
  beat_t drv  [N];
  bit    pres [N];
  bit    src_hs [N];
  int    tr_mode, gap_pct, cyc;

  // reference model state: packet lock, owner, previous winner, registered grant index
  bit    lockd;
  int    owner, lastg, gidx;
  bit    exp_hs;

  int         dut_log[$];
  int         out_data[$];
  logic [7:0] out_tid[$];
  bit         gv_prev;
  int         n_tests, n_fail;
  int         nc, pushed;
  int         exp_rr[5] = '{0, 1, 2, 3, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (!pres[i] && srcq[i].size() > 0 && $urandom_range(99) >= gap_pct) pres[i] = 1'b1;
      if (pres[i]) drv[i] = srcq[i][0];
      else drv[i] = 28'($urandom);
      s_tvalid[i]          = pres[i];
      s_tdata[i*DW +: DW]  = drv[i].data;
      s_tkeep[i]           = drv[i].keep;
      s_tstrb[i]           = drv[i].strb;
      s_tlast[i]           = drv[i].last;
      s_tid[i*TW +: TW]    = drv[i].tid;
      s_tdest[i*DEW +: DEW] = drv[i].dest;
      s_tuser[i]           = drv[i].user;
    end
    case (tr_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = cyc[0];
      default: m_tready = 1'($urandom_range(1));
    endcase
  endtask

  function automatic beat_t exp_payload();
    beat_t b = '0;
    if (lockd) begin
      b = drv[owner];
`ifdef AXIS_ARB_TID_TAG_EN
      b.tid[1:0] = 2'(owner);
`endif
    end
    return b;
  endfunction

  function automatic bit busy();
    for (int i = 0; i < N; i++) if (srcq[i].size() != 0 || pres[i]) return 1'b1;
    return lockd;
  endfunction

  // Check from negedge, advance across the next posedge, then drive new inputs.
  task automatic half();
    beat_t        ob, eb;
    logic [N-1:0] ert;
    eb  = exp_payload();
    ob  = {m_tdata, m_tkeep, m_tstrb, m_tlast, m_tid, m_tdest, m_tuser};
    ert = '0;
    if (lockd) ert[owner] = m_tready;
    chk("m_tvalid", 32'(m_tvalid), 32'(lockd && pres[owner]));
    chk("s_tready", 32'(s_tready), 32'(ert));
    chk("grant_valid", 32'(grant_valid), 32'(lockd));
    chk("grant_idx", 32'(grant_idx), gidx);
    chk("payload", 32'(ob), 32'(eb));
    if (grant_valid && !gv_prev) dut_log.push_back(int'(grant_idx));
    gv_prev = grant_valid;
    if (m_tvalid && m_tready) begin
      out_data.push_back(int'(m_tdata));
      out_tid.push_back(m_tid);
    end
    exp_hs = lockd && pres[owner] && m_tready;
    for (int i = 0; i < N; i++) src_hs[i] = pres[i] && s_tready[i];
    @(posedge ACLK);
    #1;
    if (!lockd) begin
      for (int k = 1; k <= N; k++) begin
        if (!lockd && pres[(lastg + k) % N]) begin
          lockd = 1'b1;
          owner = (lastg + k) % N;
          gidx  = owner;
        end
      end
    end else if (exp_hs && drv[owner].last) begin
      lockd = 1'b0;
      lastg = owner;
    end
    for (int i = 0; i < N; i++) begin
      if (src_hs[i]) begin
        if (srcq[i].size() > 0) void'(srcq[i].pop_front());
        pres[i] = 1'b0;
      end
    end
    cyc++;
    drive();
  endtask

  task automatic cycle();
    @(negedge ACLK);
    half();
  endtask

  task automatic apply_reset();
    #2 ARESETn = 1'b0;
    #1;
    chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_s_tready", 32'(s_tready), 32'd0);
    chk("rst_grant_valid", 32'(grant_valid), 32'd0);
    chk("rst_grant_idx", 32'(grant_idx), 32'd0);
    lockd   = 1'b0;
    owner   = 0;
    lastg   = N - 1;
    gidx    = 0;
    gv_prev = 1'b0;
    @(negedge ACLK);
    ARESETn = 1'b1;
    half();
  endtask

  task automatic new_test(input int mode, input int gap);
    tr_mode = mode;
    gap_pct = gap;
    for (int i = 0; i < N; i++) begin
      srcq[i].delete();
      pres[i] = 1'b0;
    end
    drive();
    apply_reset();
    dut_log.delete();
    out_data.delete();
    out_tid.delete();
  endtask

  task automatic push_pkt(input int s, input int len, input logic [7:0] d0, input logic [7:0] tid);
    beat_t b;
    for (int j = 0; j < len; j++) begin
      b      = 28'($urandom);
      b.data = d0 + 8'(j);
      b.tid  = tid;
      b.last = (j == len - 1);
      srcq[s].push_back(b);
    end
  endtask

  task automatic drain(input int max_cyc, output int n);
    n = 0;
    while (busy() && n < max_cyc) begin
      cycle();
      n++;
    end
    chk("drain_in_budget", 32'(n < max_cyc), 32'd1);
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    cyc      = 0;
    s_tvalid = '0;
    m_tready = 1'b0;
    for (int i = 0; i < N; i++) pres[i] = 1'b0;
    lockd = 1'b0; owner = 0; lastg = N - 1; gidx = 0;

    // reset with every source requesting, then first grant after release
    new_test(0, 0);
    for (int i = 0; i < N; i++) push_pkt(i, 4, 8'(8'h10 * i), 8'h00);
    drive();
    for (int k = 0; k < 3; k++) cycle();
    dut_log.delete();
    apply_reset();
    drain(200, nc);
    chk("first_grant_after_reset", dut_log.size() > 0 ? dut_log[0] : -1, 0);

    // round-robin with all sources streaming 3-beat packets
    new_test(0, 0);
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < N; i++) push_pkt(i, 3, 8'(8'h40 * i + 8'h10 * p), 8'h00);
    drive();
    drain(200, nc);
    for (int k = 0; k < 5; k++) chk("rr_order", k < dut_log.size() ? dut_log[k] : -1, exp_rr[k]);
    chk("rr_cycles", nc, 32);
    chk("rr_beats", out_data.size(), 24);

    // lock under toggling backpressure, competing request mid-packet
    new_test(1, 0);
    push_pkt(2, 4, 8'hA0, 8'h00);
    drive();
    cycle();
    cycle();
    push_pkt(1, 2, 8'hB0, 8'h00);
    drive();
    drain(100, nc);
    for (int k = 0; k < 4; k++)
      chk("bp_beat", k < out_data.size() ? out_data[k] : -1, 8'hA0 + k);
    chk("bp_grants", dut_log.size(), 2);
    chk("bp_second_grant", dut_log.size() > 1 ? dut_log[1] : -1, 1);

    // single-beat packets from source 3 only: wrap search returns 3, bubble each time
    new_test(0, 0);
    for (int p = 0; p < 3; p++) push_pkt(3, 1, 8'(8'h30 + p), 8'h00);
    drive();
    drain(50, nc);
    chk("sb_cycles", nc, 6);
    chk("sb_grants", dut_log.size(), 3);
    for (int k = 0; k < dut_log.size(); k++) chk("sb_grant_src", dut_log[k], 3);

    // reset after beat 2 of 5 from source 1; source 0 then wins
    new_test(0, 0);
    push_pkt(1, 5, 8'hC0, 8'h00);
    drive();
    for (int k = 0; k < 20 && out_data.size() < 2; k++) cycle();
    chk("mid_pkt_reached", out_data.size(), 2);
    push_pkt(0, 2, 8'hD0, 8'h00);
    drive();
    dut_log.delete();
    out_data.delete();
    apply_reset();
    drain(100, nc);
    chk("post_rst_grant0", dut_log.size() > 0 ? dut_log[0] : -1, 0);
    chk("post_rst_beat0", out_data.size() > 0 ? out_data[0] : -1, 8'hD0);
    chk("post_rst_grant1", dut_log.size() > 1 ? dut_log[1] : -1, 1);

    // TID pass-through / tagging from source 3
    new_test(0, 0);
    push_pkt(3, 1, 8'h5A, 8'hF0);
    drive();
    drain(20, nc);
    chk("tid_tag", out_tid.size() > 0 ? 32'(out_tid[0]) : 32'hFFFF_FFFF, 32'(EXP_TID));

    // randomized traffic, gaps and backpressure
    new_test(2, 30);
    pushed = 0;
    for (int p = 0; p < 40; p++) begin
      int s, l;
      s = $urandom_range(N - 1);
      l = $urandom_range(5, 1);
      push_pkt(s, l, 8'($urandom), 8'($urandom));
      pushed += l;
    end
    drive();
    drain(4000, nc);
    chk("rand_beats", out_data.size(), pushed);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axis_rr_arbiter.md
# axis_rr_arbiter

N-to-1 AXI-Stream packet arbiter that shares one downstream `axis_if` transmitter channel among `NUM_SRC` upstream sources. Arbitration is round-robin at packet granularity: once a source is granted, the arbiter holds the grant until that source's TLAST beat completes. The block sits between several stream producers and a single shared consumer, for example a DMA or output port, and is the sequencing point for all traffic on that channel.

## Interface
- `NUM_SRC`, 4: number of upstream sources; legal range 2..16.
- `TDATA_WIDTH`, 8: data width in bits; multiple of 8.
- `TDEST_WIDTH`, 8: TDEST width.
- `TUSER_WIDTH`, 1: TUSER width.
- `TID_WIDTH`, 8: TID width; must be ≥ `$clog2(NUM_SRC)`.
- Source vectors are flattened, with source i at slice i. `KW` = `TDATA_WIDTH/8`.

Ports:
- `ACLK`  in  1  clock; everything is rising-edge.
- `ARESETn`  in  1  reset, asynchronous assert, active-low.
- `s_tvalid`  in  NUM_SRC  per-source TVALID.
- `s_tready`  out  NUM_SRC  per-source TREADY.
- `s_tdata`  in  NUM_SRC*TDATA_WIDTH  per-source TDATA.
- `s_tkeep`, `s_tstrb`  in  NUM_SRC*KW  per-source TKEEP/TSTRB.
- `s_tlast`  in  NUM_SRC  per-source TLAST.
- `s_tid`  in  NUM_SRC*TID_WIDTH  per-source TID.
- `s_tdest`  in  NUM_SRC*TDEST_WIDTH  per-source TDEST.
- `s_tuser`  in  NUM_SRC*TUSER_WIDTH  per-source TUSER.
- `m_tvalid`, `m_tready`, `m_tdata`, `m_tkeep`, `m_tstrb`, `m_tlast`, `m_tid`, `m_tdest`, `m_tuser`: shared master channel with the matching widths; `m_tready` is an input, all others are outputs.
- `grant_valid`  out  1  high while a packet is locked.
- `grant_idx`  out  $clog2(NUM_SRC)  source currently granted.

## Operation
State machine: IDLE, LOCK.

IDLE:
- `m_tvalid` = 0.
- All `s_tready` = 0.
- All `m_*` payload outputs = 0.
- If any `s_tvalid` bit is high, choose the first requester strictly after `last_grant`, searching upward with wrap NUM_SRC-1 → 0.
- Register the chosen index into `grant_idx` and move to LOCK.

LOCK:
- All `m_*` payload outputs = the `s_*` slice at `grant_idx` (combinational mux).
- `m_tvalid` = `s_tvalid[grant_idx]`.
- `s_tready[grant_idx]` = `m_tready`; every other `s_tready` bit = 0.
- When a beat completes (`m_tvalid && m_tready && m_tlast`):
  - `last_grant` ← `grant_idx`;
  - state ← IDLE.
- Non-last beats keep the lock. A packet of any length, including a single beat, is legal.
- A granted source that drops TVALID mid-packet holds the lock, and `m_tvalid` follows it low. The arbiter never times out.

Ungranted sources see `s_tready` = 0 and must hold their data, per AXI-Stream rules.

Reset:
- `ARESETn` low forces, immediately and asynchronously:
  - state = IDLE, `grant_valid` = 0, `grant_idx` = 0;
  - `last_grant` = NUM_SRC-1, so source 0 has first priority;
  - `m_tvalid` = 0 and all `s_tready` = 0.
- Reset during a locked packet drops that packet. There is no resume.

## Timing
- Arbitration latency: 1 cycle. A request sampled in IDLE at edge k gives LOCK with the first beat presentable in cycle k+1.
- Packet overhead: 1 bubble cycle after each TLAST, spent back in IDLE, even if the same or another source is already requesting.
- Datapath latency in LOCK: 0 cycles. It is combinational in both directions, so `s_tready` depends combinationally on `m_tready`.
- `grant_valid` = (state == LOCK). It is registered and changes only on the clock or on reset.
- Fairness: with all sources requesting continuously, grants cycle 0,1,…,NUM_SRC-1,0. A single-source requester waits at most NUM_SRC-1 packets.
- Same-cycle events: the TLAST handshake and new requests in the same cycle are resolved by the IDLE→LOCK rule on the following cycle.

## Configuration
- Macro `AXIS_ARB_TID_TAG_EN`.
- Defined: the low `$clog2(NUM_SRC)` bits of `m_tid` are replaced by `grant_idx`. The upper bits pass through from the granted `s_tid`.
- Undefined: `m_tid` = granted `s_tid`, unmodified.
- No other behaviour differs.

## Test plan
- **Reset state.** Assert `ARESETn` low mid-simulation with all `s_tvalid` = 1 → `m_tvalid` = 0, `s_tready` = 0, `grant_valid` = 0. After release, the first grant is source 0.
- **Round-robin order.** NUM_SRC = 4, all sources continuously send 3-beat packets, `m_tready` = 1 → grant order 0,1,2,3,0. Each packet takes 3 beats followed by 1 idle cycle, and no beat interleaving occurs.
- **Lock under backpressure.** Source 2 sends 4 beats (0xA0..0xA3) while `m_tready` toggles 1,0,1,0…. Source 1 requests mid-packet → all 4 beats appear in order. `s_tready[1]` stays 0 until after source 2's TLAST, and source 1 is granted next.
- **Single-beat packets and wrap.** Only source 3 requests, with back-to-back TLAST=1 beats → each beat is granted to source 3 with a bubble between beats. `last_grant` wrap 3→0 search returns 3.
- **Reset mid-packet.** Assert reset after beat 2 of 5 from source 1 → the outputs clear immediately. After release, source 0 (if requesting) wins over source 1.
- **TID tag.**
  - With `AXIS_ARB_TID_TAG_EN` defined, source 3 sends `s_tid` = 0xF0 → `m_tid` = 0xF3.
  - Without the macro → `m_tid` = 0xF0.
